// File: rtl/tengigeth_rx_mac_filter.sv
// ETH0 receive destination-MAC filter, cut-through, one output register stage.
// Define TENGIGETH_RX_MAC_FILTER_MCAST_EN to also forward multicast frames.
module tengigeth_rx_mac_filter #(
    parameter int gCntWidth = 16
) (
    input  logic                 piETH0_CoreClk,
    input  logic                 piETH0_CoreReset,
    input  logic                 piMMIO_FilterEn,
    input  logic [47:0]          piMMIO_MacAddr,
    input  logic [63:0]          piMAC_Flt_Axis_tdata,
    input  logic [7:0]           piMAC_Flt_Axis_tkeep,
    input  logic                 piMAC_Flt_Axis_tlast,
    input  logic                 piMAC_Flt_Axis_tvalid,
    output logic                 poFLT_Mac_Axis_tready,
    output logic [63:0]          poFLT_Elp_Axis_tdata,
    output logic [7:0]           poFLT_Elp_Axis_tkeep,
    output logic                 poFLT_Elp_Axis_tlast,
    output logic                 poFLT_Elp_Axis_tvalid,
    input  logic                 piELP_Flt_Axis_tready,
    output logic [gCntWidth-1:0] poFLT_PassCnt,
    output logic [gCntWidth-1:0] poFLT_DropCnt
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t               state;
    logic                 oValid;
    logic [63:0]          oData;
    logic [7:0]           oKeep;
    logic                 oLast;
    logic [gCntWidth-1:0] passCnt;
    logic [gCntWidth-1:0] dropCnt;

    logic        ld;
    logic        inReady;
    logic        accept;
    logic [47:0] dst;
    logic        isRunt;
    logic        isHit;
    logic        keepFrame;
    logic        load;
    logic        passInc;
    logic        dropInc;

    assign ld      = !oValid | piELP_Flt_Axis_tready;
    // Dropped frames drain regardless of downstream backpressure.
    assign inReady = (state == DROP) ? 1'b1 : ld;
    assign accept  = piMAC_Flt_Axis_tvalid & inReady;

    assign dst = {piMAC_Flt_Axis_tdata[7:0],   piMAC_Flt_Axis_tdata[15:8],
                  piMAC_Flt_Axis_tdata[23:16], piMAC_Flt_Axis_tdata[31:24],
                  piMAC_Flt_Axis_tdata[39:32], piMAC_Flt_Axis_tdata[47:40]};

    assign isRunt = piMAC_Flt_Axis_tlast & (piMAC_Flt_Axis_tkeep[5:0] != 6'h3F);

`ifdef TENGIGETH_RX_MAC_FILTER_MCAST_EN
    assign isHit = (dst == piMMIO_MacAddr) | (&dst) | dst[40];
`else
    assign isHit = (dst == piMMIO_MacAddr) | (&dst);
`endif

    assign keepFrame = !isRunt & (!piMMIO_FilterEn | isHit);
    assign load      = accept & ((state == PASS) | ((state == IDLE) & keepFrame));
    assign passInc   = load & piMAC_Flt_Axis_tlast;
    assign dropInc   = accept & piMAC_Flt_Axis_tlast & !load;

    always_ff @(posedge piETH0_CoreClk or posedge piETH0_CoreReset) begin
        if (piETH0_CoreReset) begin
            state   <= IDLE;
            oValid  <= 1'b0;
            oData   <= '0;
            oKeep   <= '0;
            oLast   <= 1'b0;
            passCnt <= '0;
            dropCnt <= '0;
        end else begin
            if (load) begin
                oValid <= 1'b1;
                oData  <= piMAC_Flt_Axis_tdata;
                oKeep  <= piMAC_Flt_Axis_tkeep;
                oLast  <= piMAC_Flt_Axis_tlast;
            end else if (piELP_Flt_Axis_tready) begin
                oValid <= 1'b0;
            end

            if (accept) begin
                unique case (state)
                    IDLE: begin
                        if (!piMAC_Flt_Axis_tlast)
                            state <= keepFrame ? PASS : DROP;
                    end
                    PASS, DROP: begin
                        if (piMAC_Flt_Axis_tlast)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (passInc && !(&passCnt))
                passCnt <= passCnt + 1'b1;
            if (dropInc && !(&dropCnt))
                dropCnt <= dropCnt + 1'b1;
        end
    end

    assign poFLT_Mac_Axis_tready = inReady;
    assign poFLT_Elp_Axis_tdata  = oData;
    assign poFLT_Elp_Axis_tkeep  = oKeep;
    assign poFLT_Elp_Axis_tlast  = oLast;
    assign poFLT_Elp_Axis_tvalid = oValid;
    assign poFLT_PassCnt         = passCnt;
    assign poFLT_DropCnt         = dropCnt;

endmodule

// File: tb/tb_tengigeth_rx_mac_filter.sv
// Randomized self-checking bench for tengigeth_rx_mac_filter.
// A frame-level model predicts forwarded beats and saturating counts.
module tb_tengigeth_rx_mac_filter;

    localparam int CW = 12;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fltEn = 1'b1;
    logic [47:0]   macAddr = 48'h0A0B0C0D0E0F;
    logic [63:0]   inData = '0;
    logic [7:0]    inKeep = '0;
    logic          inLast = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [63:0]   outData;
    logic [7:0]    outKeep;
    logic          outLast;
    logic          outValid;
    logic          dsReady = 1'b1;
    logic [CW-1:0] passCnt;
    logic [CW-1:0] dropCnt;

    int    checks = 0;
    int    errors = 0;
    int    expPass = 0;
    int    expDrop = 0;
    int    dsMode = 0;
    bit    chkRule = 1'b0;
    beat_t expQ[$];
    beat_t obsQ[$];

    tengigeth_rx_mac_filter #(.gCntWidth(CW)) dut (
        .piETH0_CoreClk       (clk),
        .piETH0_CoreReset     (rst),
        .piMMIO_FilterEn      (fltEn),
        .piMMIO_MacAddr       (macAddr),
        .piMAC_Flt_Axis_tdata (inData),
        .piMAC_Flt_Axis_tkeep (inKeep),
        .piMAC_Flt_Axis_tlast (inLast),
        .piMAC_Flt_Axis_tvalid(inValid),
        .poFLT_Mac_Axis_tready(inReady),
        .poFLT_Elp_Axis_tdata (outData),
        .poFLT_Elp_Axis_tkeep (outKeep),
        .poFLT_Elp_Axis_tlast (outLast),
        .poFLT_Elp_Axis_tvalid(outValid),
        .piELP_Flt_Axis_tready(dsReady),
        .poFLT_PassCnt        (passCnt),
        .poFLT_DropCnt        (dropCnt)
    );

    always #5 clk = ~clk;

    // Downstream ready pattern: 0 always, 1 stalled, 2 toggling, 3 random
    always @(posedge clk) begin
        #1;
        case (dsMode)
            0: dsReady = 1'b1;
            1: dsReady = 1'b0;
            2: dsReady = ~dsReady;
            default: dsReady = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (outValid && dsReady)
                obsQ.push_back('{outData, outKeep, outLast});
            if (chkRule) begin
                checks++;
                if (inReady !== !(outValid && !dsReady)) begin
                    errors++;
                    $display("FAIL readyRule: tready=%b, required %b", inReady, !(outValid && !dsReady));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit modelKeep(beat_t b, bit en, logic [47:0] mac);
        logic [47:0] dst;
        bit runt;
        bit hit;
        for (int i = 0; i < 6; i++)
            dst[47 - 8 * i -: 8] = b.d[8 * i +: 8];
        runt = b.l && (b.k[5:0] != 6'h3F);
        hit = (dst == mac) || (dst == 48'hFFFF_FFFF_FFFF);
`ifdef TENGIGETH_RX_MAC_FILTER_MCAST_EN
        if (dst[40]) hit = 1'b1;
`endif
        return !runt && (!en || hit);
    endfunction

    task automatic doReset();
        rst = 1'b1;
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expPass = 0;
        expDrop = 0;
        expQ.delete();
        obsQ.delete();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 local, 1 broadcast, 2 foreign unicast, 3 multicast, 4 runt, 5 fixed dst
    task automatic makeFrame(input int kind, input int len, input logic [47:0] fixedDst,
                             output beat_t f[$]);
        logic [47:0] dst;
        beat_t b;
        f.delete();
        dst = {16'($urandom), $urandom};
        case (kind)
            0: dst = macAddr;
            1: dst = 48'hFFFF_FFFF_FFFF;
            2: begin
                dst[40] = 1'b0;
                if (dst == macAddr) dst[0] = ~dst[0];
            end
            3: begin
                dst[40] = 1'b1;
                if (&dst) dst[0] = 1'b0;
            end
            5: dst = fixedDst;
            default: len = 1;
        endcase
        for (int i = 0; i < len; i++) begin
            b.d = {$urandom, $urandom};
            b.k = 8'hFF;
            b.l = (i == len - 1);
            if (i == 0)
                for (int j = 0; j < 6; j++)
                    b.d[8 * j +: 8] = dst[47 - 8 * j -: 8];
            if (kind == 4) begin
                b.k = 8'($urandom);
                if (b.k[5:0] == 6'h3F) b.k[0] = 1'b0;
            end else if (len == 1) begin
                b.k = 8'($urandom) | 8'h3F;
            end else if (b.l) begin
                b.k = 8'($urandom_range(1, 255));
            end
            f.push_back(b);
        end
    endtask

    task automatic sendBeat(input beat_t b);
        int n = 0;
        inData = b.d;
        inKeep = b.k;
        inLast = b.l;
        inValid = 1'b1;
        @(negedge clk);
        while (!inReady && n < 500) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL acceptTimeout: tready=%b, required 1", inReady);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic sendFrame(input beat_t f[$], input bit flip, input bit gaps);
        if (modelKeep(f[0], fltEn, macAddr)) begin
            foreach (f[i]) expQ.push_back(f[i]);
            if (expPass < MAXC) expPass++;
        end else if (expDrop < MAXC) begin
            expDrop++;
        end
        foreach (f[i]) begin
            sendBeat(f[i]);
            if (flip) fltEn = 1'($urandom_range(0, 1));
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        dsMode = 0;
        while (obsQ.size() < expQ.size() && n < 300) begin
            n++;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (outValid !== 1'b0 || outData !== '0 || outKeep !== '0 || outLast !== 1'b0) begin
            errors++;
            $display("FAIL resetOut: valid=%b data=%h keep=%h last=%b, required all 0",
                     outValid, outData, outKeep, outLast);
        end
        doReset();
        checks++;
        if (passCnt !== '0 || dropCnt !== '0) begin
            errors++;
            $display("FAIL resetCnt: pass=%0d drop=%0d, required 0 0", passCnt, dropCnt);
        end
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL resetIdle: tready=%b valid=%b, required 1 0", inReady, outValid);
        end
    endtask

    task automatic test_unicast_latency();
        beat_t f[$];
        doReset();
        fltEn = 1'b1;
        macAddr = 48'h0A0B0C0D0E0F;
        dsMode = 0;
        for (int i = 0; i < 4; i++)
            f.push_back('{{$urandom, $urandom}, 8'hFF, (i == 3)});
        f[0].d[47:0] = 48'h0F0E0D0C0B0A;
        f[3].k = 8'h07;
        for (int i = 0; i < 4; i++) begin
            inData = f[i].d;
            inKeep = f[i].k;
            inLast = f[i].l;
            inValid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (outValid !== 1'b1 || outData !== f[i].d || outKeep !== f[i].k || outLast !== f[i].l) begin
                errors++;
                $display("FAIL latency beat %0d: got v=%b %h/%h/%b, required v=1 %h/%h/%b",
                         i, outValid, outData, outKeep, outLast, f[i].d, f[i].k, f[i].l);
            end
        end
        inValid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL latencyIdle: valid=%b, required 0", outValid);
        end
        checks++;
        if (passCnt !== CW'(1) || dropCnt !== '0) begin
            errors++;
            $display("FAIL latencyCnt: pass=%0d drop=%0d, required 1 0", passCnt, dropCnt);
        end
    endtask

    task automatic test_drop_backpressure();
        beat_t f[$];
        doReset();
        fltEn = 1'b1;
        dsMode = 1;
        @(posedge clk);
        #1;
        makeFrame(5, 3, 48'h112233445566, f);
        for (int i = 0; i < 3; i++) begin
            inData = f[i].d;
            inKeep = f[i].k;
            inLast = f[i].l;
            inValid = 1'b1;
            @(negedge clk);
            checks++;
            if (inReady !== 1'b1) begin
                errors++;
                $display("FAIL dropReady beat %0d: tready=%b, required 1", i, inReady);
            end
            @(posedge clk);
            #1;
            checks++;
            if (outValid !== 1'b0) begin
                errors++;
                $display("FAIL dropValid beat %0d: valid=%b, required 0", i, outValid);
            end
        end
        inValid = 1'b0;
        checks++;
        if (dropCnt !== CW'(1) || passCnt !== '0) begin
            errors++;
            $display("FAIL dropCnt: pass=%0d drop=%0d, required 0 1", passCnt, dropCnt);
        end
        dsMode = 3;
        makeFrame(1, 3, '0, f);
        sendFrame(f, 1'b0, 1'b0);
        waitDrain();
        checks++;
        if (obsQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL bcastCount: got %0d beats, required %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("FAIL bcastBeat %0d: got %h, required %h", i, obsQ[i], expQ[i]);
            end
        end
        checks++;
        if (passCnt !== CW'(1) || dropCnt !== CW'(1)) begin
            errors++;
            $display("FAIL bcastCnt: pass=%0d drop=%0d, required 1 1", passCnt, dropCnt);
        end
    endtask

    task automatic test_filter_off();
        beat_t f[$];
        doReset();
        fltEn = 1'b0;
        dsMode = 3;
        makeFrame(2, 5, '0, f);
        sendFrame(f, 1'b0, 1'b1);
        waitDrain();
        checks++;
        if (obsQ.size() != 5) begin
            errors++;
            $display("FAIL offCount: got %0d beats, required 5", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("FAIL offBeat %0d: got %h, required %h", i, obsQ[i], expQ[i]);
            end
        end
        checks++;
        if (passCnt !== CW'(1) || dropCnt !== '0) begin
            errors++;
            $display("FAIL offCnt: pass=%0d drop=%0d, required 1 0", passCnt, dropCnt);
        end
    endtask

    task automatic test_runt();
        beat_t f[$];
        doReset();
        fltEn = 1'b0;
        dsMode = 0;
        f.push_back('{{$urandom, $urandom}, 8'h0F, 1'b1});
        sendFrame(f, 1'b0, 1'b0);
        waitDrain();
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("FAIL runtOut: got %0d beats, required 0", obsQ.size());
        end
        checks++;
        if (dropCnt !== CW'(1) || passCnt !== '0) begin
            errors++;
            $display("FAIL runtCnt: pass=%0d drop=%0d, required 0 1", passCnt, dropCnt);
        end
    endtask

    task automatic test_backpressure();
        beat_t f[$];
        doReset();
        fltEn = 1'b1;
        macAddr = {16'($urandom), $urandom};
        dsMode = 2;
        chkRule = 1'b1;
        makeFrame(0, 8, '0, f);
        sendFrame(f, 1'b0, 1'b0);
        waitDrain();
        chkRule = 1'b0;
        checks++;
        if (obsQ.size() != 8) begin
            errors++;
            $display("FAIL bpCount: got %0d beats, required 8", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("FAIL bpBeat %0d: got %h, required %h", i, obsQ[i], expQ[i]);
            end
        end
        dsMode = 1;
        makeFrame(0, 6, '0, f);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) dsMode = 2;
            sendBeat(f[i]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outValid !== 1'b0 || passCnt !== '0 || dropCnt !== '0) begin
            errors++;
            $display("FAIL midReset: valid=%b pass=%0d drop=%0d, required 0 0 0",
                     outValid, passCnt, dropCnt);
        end
        dsMode = 0;
        doReset();
    endtask

    task automatic test_mcast();
        beat_t f[$];
        doReset();
        fltEn = 1'b1;
        macAddr = 48'h0A0B0C0D0E0F;
        dsMode = 0;
        makeFrame(5, 3, 48'h01005E000001, f);
        sendFrame(f, 1'b0, 1'b0);
        waitDrain();
        checks++;
`ifdef TENGIGETH_RX_MAC_FILTER_MCAST_EN
        if (passCnt !== CW'(1) || dropCnt !== '0 || obsQ.size() != 3) begin
            errors++;
            $display("FAIL mcast: pass=%0d drop=%0d beats=%0d, required 1 0 3",
                     passCnt, dropCnt, obsQ.size());
        end
`else
        if (passCnt !== '0 || dropCnt !== CW'(1) || obsQ.size() != 0) begin
            errors++;
            $display("FAIL mcast: pass=%0d drop=%0d beats=%0d, required 0 1 0",
                     passCnt, dropCnt, obsQ.size());
        end
`endif
    endtask

    task automatic test_random();
        beat_t f[$];
        doReset();
        macAddr = {16'($urandom), $urandom};
        dsMode = 3;
        for (int n = 0; n < 80; n++) begin
            fltEn = 1'($urandom_range(0, 1));
            makeFrame($urandom_range(0, 4), $urandom_range(1, 9), '0, f);
            sendFrame(f, 1'b1, 1'b1);
        end
        waitDrain();
        checks++;
        if (obsQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL randCount: got %0d beats, required %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin
                errors++;
                $display("FAIL randBeat %0d: got %h, required %h", i, obsQ[i], expQ[i]);
            end
        end
        checks++;
        if (int'(passCnt) != expPass || int'(dropCnt) != expDrop) begin
            errors++;
            $display("FAIL randCnt: pass=%0d drop=%0d, required %0d %0d",
                     passCnt, dropCnt, expPass, expDrop);
        end
    endtask

    task automatic test_saturation();
        beat_t fb[$];
        beat_t fr[$];
        doReset();
        fltEn = 1'b1;
        dsMode = 0;
        for (int n = 0; n < MAXC + 3; n++) begin
            makeFrame(1, 1, '0, fb);
            makeFrame(4, 1, '0, fr);
            sendFrame(fb, 1'b0, 1'b0);
            sendFrame(fr, 1'b0, 1'b0);
            if (n == MAXC - 2) begin
                @(posedge clk);
                #1;
                checks++;
                if (int'(passCnt) != MAXC - 1 || int'(dropCnt) != MAXC - 1) begin
                    errors++;
                    $display("FAIL nearSat: pass=%0d drop=%0d, required %0d %0d",
                             passCnt, dropCnt, MAXC - 1, MAXC - 1);
                end
            end
        end
        waitDrain();
        checks++;
        if (passCnt !== '1 || dropCnt !== '1) begin
            errors++;
            $display("FAIL saturate: pass=%0d drop=%0d, required %0d %0d",
                     passCnt, dropCnt, MAXC, MAXC);
        end
        checks++;
        if (obsQ.size() != expQ.size()) begin
            errors++;
            $display("FAIL satCount: got %0d beats, required %0d", obsQ.size(), expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_unicast_latency();
        test_drop_backpressure();
        test_filter_off();
        test_runt();
        test_backpressure();
        test_mcast();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
